cart_rumble_pwm: RTL and testbench
==================================

# cart_rumble_pwm

Parametrised rumble-motor driver for the Pocket cartridge port, generalising the fixed always-on rumble strobe into a request/intensity-controlled block. It gates the cartridge motor-enable line with a PWM duty derived from a core-supplied intensity. It applies a full-power spin-up burst, divides the drive carrier to a programmable rate, and enforces a maximum continuous on-time. It sits between the core's rumble register and the cart_tran_bank pins.

## Interface
Parameters:
- CARRIER_DIV, 1: clocks per carrier half-period (≥1); the value 1 toggles every clock.
- TICK_DIV, 7425: clocks per PWM tick (≥2); 100 µs at 74.25 MHz.
- DUTY_BITS, 4: intensity width; the PWM frame is 2^DUTY_BITS ticks.
- SPINUP_TICKS, 200: full-power ticks at motor start; 0 disables spin-up.
- MAX_ON_TICKS, 50000: ticks of continuous drive before forced off; 0 disables the timeout.

Ports:
- clk_74a  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  user rumble enable (menu setting)
- rumble_req  in  1  level request from the core
- intensity  in  DUTY_BITS  requested duty; 0 = off, all-ones = 100 %
- motor_on  out  1  registered motor gate, mirrors the pin state
- timed_out  out  1  high while in COOLDOWN
- cart_tran_bank0  out  [7:4]  bit 6 = active-low motor enable; bits 7, 5, 4 = 1
- cart_tran_bank3  out  [7:0]  bit 1 = drive carrier; other bits 0
- cart_tran_bank0_dir, cart_tran_bank3_dir  out  1  constant 1
- cart_tran_bank1_dir, cart_tran_bank2_dir  out  1  constant 0

## Operation
- Tick prescaler: a free-running counter 0..TICK_DIV-1, cleared by reset. The tick strobe is high for one clock when the counter wraps.
- PWM slot counter: 0..2^DUTY_BITS-1, advances on each tick and wraps.
  - duty_lat is loaded from intensity on the tick that wraps the slot to 0, and on FSM entry to SPINUP.
  - pwm_gate = (duty_lat == all-ones) | (slot < duty_lat).
- go = enable & rumble_req & (intensity != 0).
- FSM states:
  - IDLE: gate 0. Enters SPINUP when go. On entry to SPINUP, spin_cnt and on_cnt are cleared and the slot counter is reset to 0.
  - SPINUP: gate 1. spin_cnt increments per tick. Goes to RUN on the tick where spin_cnt == SPINUP_TICKS-1. If SPINUP_TICKS = 0, IDLE goes straight to RUN.
  - RUN: gate = pwm_gate.
  - COOLDOWN: gate 0, timed_out 1. Exits to IDLE only when rumble_req = 0; enable and intensity are ignored in this state.
- on_cnt counts ticks in SPINUP and RUN. When it reaches MAX_ON_TICKS, the FSM enters COOLDOWN.
- Priority in SPINUP and RUN: !go goes to IDLE, which wins over both the timeout and spin-up completion in the same cycle.
- Output stage, all registered:
  - motor_on <= gate.
  - cart_tran_bank0[6] <= ~gate.
  - Carrier divider runs only while motor_on = 1. bank3[1] toggles when the divider reaches CARRIER_DIV-1.
  - While motor_on = 0, the divider is cleared and bank3[1] is held at 0.
- Counter widths: each counter is sized with $clog2 of its maximum. No counter may wrap past its terminal value.

## Timing
- Reset values:
  - state = IDLE, motor_on = 0, timed_out = 0, all counters = 0.
  - cart_tran_bank0 = 4'b1111, cart_tran_bank3 = 8'h00.
  - Direction outputs are constant from reset onward.
- Start latency: go is sampled high at edge N. The state is SPINUP after N, motor_on = 1 and bank0[6] = 0 after N+1. With CARRIER_DIV = 1, the first bank3[1] rise is at N+2.
- Stop latency: go is low at edge N. The state is IDLE after N, motor_on = 0 after N+1, and bank3[1] = 0 after N+2.
- A change to intensity takes effect at the next frame boundary. Intensity going to 0 is the exception: it stops the motor immediately through go.
- Carrier period in steady state is 2*CARRIER_DIV clocks.
- Mid-operation reset forces all outputs to their reset values asynchronously.

## Test plan
- Reset, then idle for 100 clocks -> bank0 = 4'hF, bank3 = 0, motor_on = 0, dirs = 1/0/0/1.
- TICK_DIV = 4, SPINUP_TICKS = 3, intensity = 4'hF, req asserted at edge N -> bank0[6] = 0 from N+1. bank3[1] toggles every clock from N+2. Gate stays continuous through the SPINUP→RUN change.
- Intensity = 4 with DUTY_BITS = 4, SPINUP_TICKS = 0, TICK_DIV = 4 -> motor_on is high 4 ticks of every 16 (16 of every 64 clocks), phase-aligned to slot 0.
- MAX_ON_TICKS = 10, req held high -> COOLDOWN after 10 ticks, motor_on = 0, timed_out = 1. With req still high the block stays off. After req drops for one clock and is reasserted, SPINUP restarts.
- CARRIER_DIV = 3 at full duty -> bank3[1] has a period of 6 clocks. Dropping enable mid-carrier -> bank3[1] = 0 within 2 clocks.
- Assert reset during RUN -> outputs return to reset values the same cycle. After release the FSM sits in IDLE until go is sampled again.

Source files
------------

// File: rtl/cart_rumble_pwm.sv
// cart_rumble_pwm: PWM rumble-motor driver for the Pocket cartridge port.
// Spin-up burst, frame-aligned duty, carrier divider and on-time limit.
module cart_rumble_pwm #(
   parameter int CARRIER_DIV  = 1,
   parameter int TICK_DIV     = 7425,
   parameter int DUTY_BITS    = 4,
   parameter int SPINUP_TICKS = 200,
   parameter int MAX_ON_TICKS = 50000
) (
   input  logic                 clk_74a,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 rumble_req,
   input  logic [DUTY_BITS-1:0] intensity,
   output logic                 motor_on,
   output logic                 timed_out,
   output logic [7:4]           cart_tran_bank0,
   output logic [7:0]           cart_tran_bank3,
   output logic                 cart_tran_bank0_dir,
   output logic                 cart_tran_bank1_dir,
   output logic                 cart_tran_bank2_dir,
   output logic                 cart_tran_bank3_dir
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = (SPINUP_TICKS > 1) ? $clog2(SPINUP_TICKS) : 1;
   localparam int OW = (MAX_ON_TICKS > 0) ? $clog2(MAX_ON_TICKS + 1) : 1;
   localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

   localparam bit HAS_SPIN = (SPINUP_TICKS != 0);
   localparam bit TMO_EN   = (MAX_ON_TICKS != 0);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SPIN_LAST =
      SW'(HAS_SPIN ? SPINUP_TICKS - 1 : 0);
   localparam logic [OW-1:0] ON_MAX  = OW'(MAX_ON_TICKS);
   localparam logic [OW-1:0] ON_LAST =
      OW'(TMO_EN ? MAX_ON_TICKS - 1 : 0);
   localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SPINUP,
      RUN,
      COOLDOWN
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [TW-1:0]        tick_cnt;
   logic [DUTY_BITS-1:0] slot;
   logic [DUTY_BITS-1:0] duty_lat;
   logic [SW-1:0]        spin_cnt;
   logic [OW-1:0]        on_cnt;
   logic [CW-1:0]        car_cnt;
   logic                 carrier;
   logic                 mot_n;

   logic tick;
   logic go;
   logic pwm_gate;
   logic spin_done;
   logic tmo;
   logic gate;
   logic start;

   assign tick      = (tick_cnt == TICK_LAST);
   assign go        = enable & rumble_req & (|intensity);
   assign pwm_gate  = (&duty_lat) | (slot < duty_lat);
   assign spin_done = tick & (spin_cnt == SPIN_LAST);
   assign tmo       = TMO_EN & tick & (on_cnt == ON_LAST);
   assign timed_out = (state == COOLDOWN);

   // Free-running tick prescaler.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // Slot counter and duty latch; re-aligned to slot 0 at motor start.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         slot     <= '0;
         duty_lat <= '0;
      end else if (start) begin
         slot     <= '0;
         duty_lat <= intensity;
      end else if (tick) begin
         slot <= slot + 1'b1;
         if (&slot)
            duty_lat <= intensity;
      end
   end

   // Spin-up and continuous on-time counters, saturating.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         spin_cnt <= '0;
         on_cnt   <= '0;
      end else if (start) begin
         spin_cnt <= '0;
         on_cnt   <= '0;
      end else if (tick) begin
         if (state == SPINUP && spin_cnt != SPIN_LAST)
            spin_cnt <= spin_cnt + 1'b1;
         if (TMO_EN && (state == SPINUP || state == RUN)
             && on_cnt != ON_MAX)
            on_cnt <= on_cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state and motor gate; a dropped request beats everything.
   always_comb begin
      state_nx = state;
      gate     = 1'b0;
      start    = 1'b0;
      unique case (state)
         IDLE: begin
            if (go) begin
               start    = 1'b1;
               state_nx = HAS_SPIN ? SPINUP : RUN;
            end
         end
         SPINUP: begin
            gate = 1'b1;
            if (!go)
               state_nx = IDLE;
            else if (tmo)
               state_nx = COOLDOWN;
            else if (spin_done)
               state_nx = RUN;
         end
         RUN: begin
            gate = pwm_gate;
            if (!go)
               state_nx = IDLE;
            else if (tmo)
               state_nx = COOLDOWN;
         end
         COOLDOWN: begin
            if (!rumble_req)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Registered motor gate and active-low pin copy.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         motor_on <= 1'b0;
         mot_n    <= 1'b1;
      end else begin
         motor_on <= gate;
         mot_n    <= ~gate;
      end
   end

   // Carrier divider, parked low whenever the motor is off.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         car_cnt <= '0;
         carrier <= 1'b0;
      end else if (!motor_on) begin
         car_cnt <= '0;
         carrier <= 1'b0;
      end else if (car_cnt == CAR_LAST) begin
         car_cnt <= '0;
         carrier <= ~carrier;
      end else begin
         car_cnt <= car_cnt + 1'b1;
      end
   end

   assign cart_tran_bank0     = {1'b1, mot_n, 2'b11};
   assign cart_tran_bank3     = {6'b0, carrier, 1'b0};
   assign cart_tran_bank0_dir = 1'b1;
   assign cart_tran_bank1_dir = 1'b0;
   assign cart_tran_bank2_dir = 1'b0;
   assign cart_tran_bank3_dir = 1'b1;

endmodule

// File: tb/tb_cart_rumble_pwm.sv
// tb_cart_rumble_pwm: scoreboard bench for cart_rumble_pwm.
// Two instances: spin-up/timeout (A) and pwm/carrier/reset (B).
module tb_cart_rumble_pwm;

   logic clk_74a = 1'b0;
   logic reset   = 1'b1;

   logic       en_a  = 1'b0;
   logic       req_a = 1'b0;
   logic [3:0] int_a = 4'h0;
   logic       mot_a, to_a;
   logic [7:4] b0_a;
   logic [7:0] b3_a;
   logic       d0_a, d1_a, d2_a, d3_a;

   logic       en_b  = 1'b0;
   logic       req_b = 1'b0;
   logic [3:0] int_b = 4'h0;
   logic       mot_b, to_b;
   logic [7:4] b0_b;
   logic [7:0] b3_b;
   logic       d0_b, d1_b, d2_b, d3_b;

   int cyc    = 0;
   int r_rel  = 0;
   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int         due;
      int         sel;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];

   always #5 clk_74a = ~clk_74a;

   always @(posedge clk_74a) cyc <= cyc + 1;

   cart_rumble_pwm #(
      .CARRIER_DIV (1),
      .TICK_DIV    (4),
      .DUTY_BITS   (4),
      .SPINUP_TICKS(3),
      .MAX_ON_TICKS(10)
   ) u_a (
      .clk_74a            (clk_74a),
      .reset              (reset),
      .enable             (en_a),
      .rumble_req         (req_a),
      .intensity          (int_a),
      .motor_on           (mot_a),
      .timed_out          (to_a),
      .cart_tran_bank0    (b0_a),
      .cart_tran_bank3    (b3_a),
      .cart_tran_bank0_dir(d0_a),
      .cart_tran_bank1_dir(d1_a),
      .cart_tran_bank2_dir(d2_a),
      .cart_tran_bank3_dir(d3_a)
   );

   cart_rumble_pwm #(
      .CARRIER_DIV (3),
      .TICK_DIV    (4),
      .DUTY_BITS   (4),
      .SPINUP_TICKS(0),
      .MAX_ON_TICKS(0)
   ) u_b (
      .clk_74a            (clk_74a),
      .reset              (reset),
      .enable             (en_b),
      .rumble_req         (req_b),
      .intensity          (int_b),
      .motor_on           (mot_b),
      .timed_out          (to_b),
      .cart_tran_bank0    (b0_b),
      .cart_tran_bank3    (b3_b),
      .cart_tran_bank0_dir(d0_b),
      .cart_tran_bank1_dir(d1_b),
      .cart_tran_bank2_dir(d2_b),
      .cart_tran_bank3_dir(d3_b)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want)
         $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  tag, cyc, got, want);
      else
         n_pass++;
   endtask

   function automatic logic [7:0] obs(input int sel);
      logic [7:0] v;
      v = 8'h00;
      case (sel)
         0: v = {7'b0, mot_a};
         1: v = {4'b0, b0_a};
         2: v = b3_a;
         3: v = {7'b0, to_a};
         4: v = {7'b0, mot_b};
         5: v = {4'b0, b0_b};
         6: v = b3_b;
         7: v = {7'b0, to_b};
         default: v = 8'hxx;
      endcase
      return v;
   endfunction

   task automatic exp_at(input int due, input int sel,
                         input logic [7:0] v, input string tag);
      exp_t e;
      e.due = due;
      e.sel = sel;
      e.val = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Pop and compare every expectation due after the latest edge.
   always @(negedge clk_74a) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            chk(sb[i].tag, 32'(obs(sb[i].sel)), 32'(sb[i].val));
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk_74a);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   // Return when the next edge is a prescaler tick (TICK_DIV = 4).
   task automatic align4();
      while (((cyc + 1 - r_rel) % 4) != 0) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      int m;
      int k;
      int f;
      int d;

      repeat (3) step();
      chk("rst_mot_a", 32'(mot_a), 32'h0);
      chk("rst_b0_a", 32'(b0_a), 32'hF);
      chk("rst_b3_a", 32'(b3_a), 32'h0);
      chk("rst_to_a", 32'(to_a), 32'h0);
      reset = 1'b0;
      r_rel = cyc;

      repeat (100) step();
      chk("idle_mot_a", 32'(mot_a), 32'h0);
      chk("idle_b0_a", 32'(b0_a), 32'hF);
      chk("idle_b3_a", 32'(b3_a), 32'h0);
      chk("idle_mot_b", 32'(mot_b), 32'h0);
      chk("idle_b0_b", 32'(b0_b), 32'hF);
      chk("idle_b3_b", 32'(b3_b), 32'h0);
      chk("dirs_a", 32'({d0_a, d1_a, d2_a, d3_a}), 32'h9);
      chk("dirs_b", 32'({d0_b, d1_b, d2_b, d3_b}), 32'h9);

      // A: spin-up, continuous gate, timeout, cooldown, restart
      en_a  = 1'b1;
      int_a = 4'hF;
      align4();
      n = cyc + 1;
      req_a = 1'b1;
      exp_at(n, 0, 8'h00, "a_start_lat");
      exp_at(n + 1, 2, 8'h00, "a_car_first");
      exp_at(n + 1, 1, 8'hB, "a_b0_on");
      for (int e = n + 1; e <= n + 40; e++)
         exp_at(e, 0, 8'h01, "a_gate_on");
      for (int e = n + 2; e <= n + 41; e++)
         exp_at(e, 2, ((e - n) % 2 == 0) ? 8'h02 : 8'h00, "a_car");
      exp_at(n + 39, 3, 8'h00, "a_to_early");
      exp_at(n + 40, 3, 8'h01, "a_to_set");
      exp_at(n + 41, 0, 8'h00, "a_mot_cool");
      exp_at(n + 41, 1, 8'hF, "a_b0_cool");
      exp_at(n + 42, 2, 8'h00, "a_car_cool");
      exp_at(n + 60, 0, 8'h00, "a_cool_hold");
      exp_at(n + 60, 3, 8'h01, "a_cool_to");
      wait_until(n + 61);
      en_a  = 1'b0;
      int_a = 4'h0;
      wait_until(n + 65);
      en_a  = 1'b1;
      int_a = 4'hF;
      exp_at(n + 66, 3, 8'h01, "a_cool_ign");
      exp_at(n + 70, 3, 8'h01, "a_cool_ign2");
      exp_at(n + 70, 0, 8'h00, "a_cool_off");
      wait_until(n + 70);
      req_a = 1'b0;
      exp_at(n + 71, 3, 8'h00, "a_cool_exit");
      wait_until(n + 71);
      req_a = 1'b1;
      exp_at(n + 72, 0, 8'h00, "a_restart_lat");
      exp_at(n + 73, 0, 8'h01, "a_restart");
      exp_at(n + 73, 1, 8'hB, "a_restart_b0");
      wait_until(n + 80);
      req_a = 1'b0;
      exp_at(n + 81, 0, 8'h01, "a_stop_lat");
      exp_at(n + 82, 0, 8'h00, "a_stop");
      exp_at(n + 82, 1, 8'hF, "a_stop_b0");
      exp_at(n + 83, 2, 8'h00, "a_stop_car");
      exp_at(n + 84, 2, 8'h00, "a_stop_car2");
      wait_until(n + 90);

      // B: duty 4 -> 12 -> 15 at frame boundaries, then carrier /3
      int_b = 4'h4;
      req_b = 1'b1;
      align4();
      n = cyc + 1;
      en_b = 1'b1;
      for (int e = n + 1; e <= n + 230; e++) begin
         f = (e - n - 1) / 64;
         d = (f < 2) ? 4 : ((f == 2) ? 12 : 16);
         exp_at(e, 4, (((e - n - 1) % 64) < d * 4) ? 8'h01 : 8'h00,
                "b_pwm");
      end
      for (int e = n + 194; e <= n + 230; e++)
         exp_at(e, 6,
                (e < n + 196) ? 8'h00 :
                ((((e - n - 196) / 3) % 2 == 0) ? 8'h02 : 8'h00),
                "b_car3");
      wait_until(n + 80);
      int_b = 4'hC;
      wait_until(n + 150);
      int_b = 4'hF;
      wait_until(n + 231);
      en_b = 1'b0;
      m = n + 232;
      exp_at(m, 4, 8'h01, "b_stop_lat");
      exp_at(m + 1, 4, 8'h00, "b_stop");
      exp_at(m + 1, 5, 8'hF, "b_stop_b0");
      exp_at(m + 2, 6, 8'h00, "b_stop_car");
      wait_until(m + 10);

      // B: asynchronous reset while running
      en_b = 1'b1;
      k = cyc;
      exp_at(k + 2, 4, 8'h01, "b_pre_rst");
      wait_until(k + 6);
      chk("b_run_car", 32'(b3_b), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_mot", 32'(mot_b), 32'h0);
      chk("rst_async_b0", 32'(b0_b), 32'hF);
      chk("rst_async_b3", 32'(b3_b), 32'h0);
      chk("rst_async_to", 32'(to_b), 32'h0);
      en_b = 1'b0;
      step();
      step();
      reset = 1'b0;
      repeat (20) step();
      chk("b_idle_post_rst", 32'(mot_b), 32'h0);
      en_b = 1'b1;
      k = cyc;
      exp_at(k + 1, 4, 8'h00, "b_go_lat");
      exp_at(k + 2, 4, 8'h01, "b_go_again");
      repeat (6) step();
      chk("sb_drain", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
